// File: rtl/keypad_pkg.sv
// ============================================================================
// Module   : keypad_pkg
// Purpose  : Shared keypad types, matrix size and key-to-hex mapping.
// Revision : 1.0
// ============================================================================
`default_nettype none

package keypad_pkg;

    localparam int NROWS = 4;
    localparam int NCOLS = 4;

    typedef enum logic [0:0] {
        SCAN    = 1'b0,
        PRESSED = 1'b1
    } state_t;

    // Column 0 is the leftmost key of each row.
    function automatic logic [3:0] key_map(input logic [1:0] row_idx,
                                           input logic [1:0] col_idx);
        logic [3:0] code;
        case ({row_idx, col_idx})
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h2;
            4'h2:    code = 4'h3;
            4'h3:    code = 4'hA;
            4'h4:    code = 4'h4;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h6;
            4'h7:    code = 4'hB;
            4'h8:    code = 4'h7;
            4'h9:    code = 4'h8;
            4'hA:    code = 4'h9;
            4'hB:    code = 4'hC;
            4'hC:    code = 4'hE;
            4'hD:    code = 4'h0;
            4'hE:    code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchronizer for asynchronous level inputs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/keypad_scanner.sv
// ============================================================================
// Module   : keypad_scanner
// Purpose  : 4x4 matrix keypad row scanner that locks onto the first key seen.
// Revision : 1.0
// ============================================================================
`default_nettype none

module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int RELEASE_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCOLS-1:0] cols_n,
    output logic [NROWS-1:0] rows_n,
    output logic [NROWS-1:0] row_pressed,
    output logic [NCOLS-1:0] col_pressed,
    output logic             key_pressed,
    output logic [3:0]       key_code,
    output logic             new_key
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int REL_W = $clog2(RELEASE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_CYCLES - 1);

    logic [NCOLS-1:0] cols_s;

    state_t           state_q;
    logic [1:0]       ridx_q;
    logic [CNT_W-1:0] cnt_q;
    logic [REL_W-1:0] rel_q;
    logic [NROWS-1:0] rows_n_q;
    logic [NROWS-1:0] row_pressed_q;
    logic [NCOLS-1:0] col_pressed_q;
    logic             key_pressed_q;
    logic [3:0]       key_code_q;
    logic             new_key_q;

    logic [1:0]       low_col_idx;
    logic [NCOLS-1:0] low_col_oh;

    sync_2ff #(
        .WIDTH (NCOLS)
    ) u_col_sync (
        .clk   (clk),
        .reset (reset),
        .d     (~cols_n),
        .q     (cols_s)
    );

    // Walk from the highest column down so the lowest asserted one wins.
    always_comb begin
        low_col_idx = '0;
        low_col_oh  = '0;
        for (int c = NCOLS - 1; c >= 0; c--) begin
            if (cols_s[c]) begin
                low_col_idx   = 2'(c);
                low_col_oh    = '0;
                low_col_oh[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= SCAN;
            ridx_q        <= '0;
            cnt_q         <= '0;
            rel_q         <= '0;
            rows_n_q      <= 4'b1110;
            row_pressed_q <= '0;
            col_pressed_q <= '0;
            key_pressed_q <= 1'b0;
            key_code_q    <= '0;
            new_key_q     <= 1'b0;
        end else begin
            new_key_q <= 1'b0;
            case (state_q)
                SCAN: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (|cols_s) begin
                            state_q       <= PRESSED;
                            rel_q         <= '0;
                            row_pressed_q <= 4'b0001 << ridx_q;
                            col_pressed_q <= low_col_oh;
                            key_code_q    <= key_map(ridx_q, low_col_idx);
                            key_pressed_q <= 1'b1;
                            new_key_q     <= 1'b1;
                        end else begin
                            ridx_q   <= ridx_q + 2'd1;
                            rows_n_q <= ~(4'b0001 << (ridx_q + 2'd1));
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    // Only the locked column matters; anything else is ignored.
                    if ((cols_s & col_pressed_q) == '0) begin
                        if (rel_q == REL_LAST) begin
                            state_q       <= SCAN;
                            rel_q         <= '0;
                            cnt_q         <= '0;
                            ridx_q        <= ridx_q + 2'd1;
                            rows_n_q      <= ~(4'b0001 << (ridx_q + 2'd1));
                            row_pressed_q <= '0;
                            col_pressed_q <= '0;
                            key_pressed_q <= 1'b0;
                        end else begin
                            rel_q <= rel_q + REL_W'(1);
                        end
                    end else begin
                        rel_q <= '0;
                    end
                end
                default: begin
                    state_q <= SCAN;
                end
            endcase
        end
    end

    assign rows_n      = rows_n_q;
    assign row_pressed = row_pressed_q;
    assign col_pressed = col_pressed_q;
    assign key_pressed = key_pressed_q;
    assign key_code    = key_code_q;
    assign new_key     = new_key_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// ============================================================================
// Module   : tb_keypad_scanner
// Purpose  : Self-checking bench for keypad_scanner with a modelled key matrix.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_keypad_scanner;

    localparam int SD          = 4;
    localparam int RC          = 3;
    localparam int LOCK_BUDGET = 4 * SD + 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] cols_n;
    logic [3:0] rows_n;
    logic [3:0] row_pressed;
    logic [3:0] col_pressed;
    logic       key_pressed;
    logic [3:0] key_code;
    logic       new_key;

    logic [15:0] keys = '0;

    typedef struct packed {
        logic [3:0] code;
        logic [3:0] row;
        logic [3:0] col;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   nk_count = 0;

    keypad_scanner #(
        .SCAN_DIV       (SD),
        .RELEASE_CYCLES (RC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cols_n      (cols_n),
        .rows_n      (rows_n),
        .row_pressed (row_pressed),
        .col_pressed (col_pressed),
        .key_pressed (key_pressed),
        .key_code    (key_code),
        .new_key     (new_key)
    );

    always #5 clk = ~clk;

    // A held key pulls its column low only while its row is driven low.
    always_comb begin
        cols_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !rows_n[r]) cols_n[c] = 1'b0;
            end
        end
    end

    always @(negedge clk) if (new_key === 1'b1) nk_count++;

    task automatic wait_lock(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (new_key === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_unlock(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (key_pressed === 1'b0) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        keys  = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rows_n, row_pressed, col_pressed, key_code, key_pressed, new_key} !== {4'b1110, 12'h000, 2'b00}) begin
            errors++;
            $display("FAIL reset_state got rows=%b row=%b col=%b code=%h kp=%b nk=%b want rows=1110 rest 0",
                     rows_n, row_pressed, col_pressed, key_code, key_pressed, new_key);
        end
        reset = 1'b0;
    endtask

    task automatic test_scan();
        logic [3:0] exp_rows;
        for (int i = 0; i < 20; i++) begin
            exp_rows = 4'b0001 << ((i / 4) % 4);
            exp_rows = ~exp_rows;
            checks++;
            if (rows_n !== exp_rows || key_pressed !== 1'b0 || new_key !== 1'b0) begin
                errors++;
                $display("FAIL scan_cycle%0d got rows=%b kp=%b nk=%b want rows=%b kp=0 nk=0",
                         i, rows_n, key_pressed, new_key, exp_rows);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_press5();
        bit   seen;
        exp_t e;
        keys[1*4+1] = 1'b1;
        sb.push_back('{code: 4'h5, row: 4'b0010, col: 4'b0010});
        wait_lock(LOCK_BUDGET, seen);
        e = sb.pop_front();
        checks++;
        if (!seen || {key_code, row_pressed, col_pressed, key_pressed} !== {e.code, e.row, e.col, 1'b1}) begin
            errors++;
            $display("FAIL lock_5 got seen=%0d code=%h row=%b col=%b kp=%b want code=%h row=%b col=%b kp=1",
                     seen, key_code, row_pressed, col_pressed, key_pressed, e.code, e.row, e.col);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (new_key !== 1'b0 || key_pressed !== 1'b1 || rows_n !== 4'b1101) begin
                errors++;
                $display("FAIL hold_5_cycle%0d got nk=%b kp=%b rows=%b want nk=0 kp=1 rows=1101",
                         i, new_key, key_pressed, rows_n);
            end
        end
    endtask

    task automatic test_release5();
        keys = '0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            checks++;
            if (key_pressed !== (i < 5)) begin
                errors++;
                $display("FAIL release_kp_cycle%0d got kp=%b want %b", i, key_pressed, (i < 5));
            end
        end
        checks++;
        if ({rows_n, key_code, row_pressed, col_pressed} !== {4'b1011, 4'h5, 8'h00}) begin
            errors++;
            $display("FAIL release_state got rows=%b code=%h row=%b col=%b want rows=1011 code=5 row=0000 col=0000",
                     rows_n, key_code, row_pressed, col_pressed);
        end
    endtask

    task automatic test_lock_ignores_others();
        bit   seen;
        exp_t e;
        int   base;
        keys[1*4+1] = 1'b1;
        sb.push_back('{code: 4'h5, row: 4'b0010, col: 4'b0010});
        wait_lock(LOCK_BUDGET, seen);
        e = sb.pop_front();
        checks++;
        if (!seen || {key_code, row_pressed, col_pressed} !== {e.code, e.row, e.col}) begin
            errors++;
            $display("FAIL relock_5 got seen=%0d code=%h row=%b col=%b want code=%h row=%b col=%b",
                     seen, key_code, row_pressed, col_pressed, e.code, e.row, e.col);
        end
        @(posedge clk);
        base = nk_count;
        @(negedge clk);
        keys[2*4+2] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (new_key !== 1'b0 || rows_n !== 4'b1101 || key_code !== 4'h5) begin
                errors++;
                $display("FAIL ignore_9_cycle%0d got nk=%b rows=%b code=%h want nk=0 rows=1101 code=5",
                         i, new_key, rows_n, key_code);
            end
        end
        keys[1*4+1] = 1'b0;
        sb.push_back('{code: 4'h9, row: 4'b0100, col: 4'b0100});
        wait_lock(LOCK_BUDGET, seen);
        e = sb.pop_front();
        checks++;
        if (!seen || {key_code, row_pressed, col_pressed} !== {e.code, e.row, e.col}) begin
            errors++;
            $display("FAIL lock_9 got seen=%0d code=%h row=%b col=%b want code=%h row=%b col=%b",
                     seen, key_code, row_pressed, col_pressed, e.code, e.row, e.col);
        end
        @(posedge clk);
        checks++;
        if (nk_count !== base + 1) begin
            errors++;
            $display("FAIL new_key_count_9 got %0d pulses want 1", nk_count - base);
        end
        keys = '0;
        wait_unlock(12);
        checks++;
        if (key_pressed !== 1'b0) begin
            errors++;
            $display("FAIL unlock_9 got kp=%b want 0", key_pressed);
        end
    endtask

    task automatic test_multi_column();
        bit   seen;
        exp_t e;
        for (int t = 0; t < 2; t++) begin
            keys = (t == 0) ? 16'h0050 : 16'hA000;
            if (t == 0) sb.push_back('{code: 4'h4, row: 4'b0010, col: 4'b0001});
            else        sb.push_back('{code: 4'h0, row: 4'b1000, col: 4'b0010});
            wait_lock(LOCK_BUDGET, seen);
            e = sb.pop_front();
            checks++;
            if (!seen || {key_code, row_pressed, col_pressed} !== {e.code, e.row, e.col}) begin
                errors++;
                $display("FAIL multicol_%0d got seen=%0d code=%h row=%b col=%b want code=%h row=%b col=%b",
                         t, seen, key_code, row_pressed, col_pressed, e.code, e.row, e.col);
            end
            keys = '0;
            wait_unlock(12);
            checks++;
            if (key_pressed !== 1'b0 || key_code !== e.code) begin
                errors++;
                $display("FAIL multicol_unlock_%0d got kp=%b code=%h want kp=0 code=%h",
                         t, key_pressed, key_code, e.code);
            end
        end
    endtask

    task automatic test_glitch_reset();
        bit   seen;
        exp_t e;
        int   base;
        keys[3*4+3] = 1'b1;
        sb.push_back('{code: 4'hD, row: 4'b1000, col: 4'b1000});
        wait_lock(LOCK_BUDGET, seen);
        e = sb.pop_front();
        checks++;
        if (!seen || {key_code, row_pressed, col_pressed} !== {e.code, e.row, e.col}) begin
            errors++;
            $display("FAIL lock_D got seen=%0d code=%h row=%b col=%b want code=%h row=%b col=%b",
                     seen, key_code, row_pressed, col_pressed, e.code, e.row, e.col);
        end
        @(posedge clk);
        base = nk_count;
        for (int g = 1; g < RC; g++) begin
            @(negedge clk);
            keys[3*4+3] = 1'b0;
            repeat (g) @(negedge clk);
            keys[3*4+3] = 1'b1;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                checks++;
                if (key_pressed !== 1'b1 || new_key !== 1'b0) begin
                    errors++;
                    $display("FAIL glitch%0d_cycle%0d got kp=%b nk=%b want kp=1 nk=0",
                             g, i, key_pressed, new_key);
                end
            end
        end
        @(posedge clk);
        checks++;
        if (nk_count !== base) begin
            errors++;
            $display("FAIL glitch_new_key got %0d extra pulses want 0", nk_count - base);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({rows_n, row_pressed, col_pressed, key_code, key_pressed, new_key} !== {4'b1110, 12'h000, 2'b00}) begin
            errors++;
            $display("FAIL midpress_reset got rows=%b row=%b col=%b code=%h kp=%b nk=%b want rows=1110 rest 0",
                     rows_n, row_pressed, col_pressed, key_code, key_pressed, new_key);
        end
        keys = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_scan();
        test_press5();
        test_release5();
        test_lock_ignores_others();
        test_multi_column();
        test_glitch_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad by driving one row at a time and sampling the columns through a two-flop synchronizer. It locks onto the first pressed key, reports its row, column and hex code, and holds them until release. It sits directly upstream of the debouncer: `col_pressed` and `key_pressed` feed the debouncer's `sig_in` and `key_pressed`, and `key_code`/`new_key` go on to the digit-display logic.

## Interface
Parameters:
- `SCAN_DIV`, default 1000: cycles each row is driven before columns are sampled; legal range ≥ 3.
- `RELEASE_CYCLES`, default 1000: consecutive cycles the locked column must read released before unlock; legal range ≥ 1.

Ports:
- `clk`  in  1  system clock; the block's only clock.
- `reset`  in  1  synchronous, active-high reset.
- `cols_n`  in  4  raw keypad columns, asynchronous, active-low (pulled up).
- `rows_n`  out  4  row drive, one-hot active-low.
- `row_pressed`  out  4  one-hot active-high row of the locked key.
- `col_pressed`  out  4  one-hot active-high column of the locked key.
- `key_pressed`  out  1  high while a key is locked.
- `key_code`  out  4  hex value of the locked key.
- `new_key`  out  1  single-cycle pulse on lock.

## Operation
- Column path: `cols_n` is inverted, then passes a 2-flop synchronizer to give `cols_s`, active-high. Only `cols_s` is used internally.
- Key map, row r / col c, c = 0 leftmost:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- FSM states: SCAN, PRESSED.
- SCAN:
  - Drive row `ridx` (`rows_n` = ~(1<<`ridx`)).
  - `cnt` counts 0..SCAN_DIV-1.
  - At `cnt`==SCAN_DIV-1 with `cols_s` != 0:
    - Next state PRESSED.
    - Latch `row_pressed` = 1<<`ridx`.
    - Latch `col_pressed` = lowest set bit of `cols_s`.
    - Latch `key_code` from the map.
    - Set `key_pressed` = 1 and `new_key` = 1.
  - At `cnt`==SCAN_DIV-1 with `cols_s` == 0: `ridx` <= `ridx`+1 mod 4, `cnt` <= 0.
- PRESSED:
  - `rows_n` holds the locked row.
  - `rel` counts consecutive cycles in which `cols_s` & `col_pressed` == 0, and resets to 0 whenever the locked column reads asserted.
  - At `rel`==RELEASE_CYCLES-1 with the column still released, the next state is SCAN:
    - Clear `key_pressed`, `row_pressed`, `col_pressed`. `key_code` retains its last value.
    - `ridx` <= locked row + 1 mod 4, `cnt` <= 0.
  - Other keys pressed while locked are ignored, including keys in the same row or other rows.
- Multiple columns asserted at the sample point: the lowest column index wins; no error is flagged.
- Reset values:
  - State SCAN, `ridx` 0, `cnt` 0, `rel` 0.
  - `rows_n` 4'b1110.
  - `row_pressed`, `col_pressed`, `key_code` 0; `key_pressed` 0, `new_key` 0.
  - Synchronizer flops 0.
- Reset mid-operation has immediate effect at the next edge from any state. No `new_key` pulse is emitted on reset.

## Timing
- All outputs are registered. `rows_n` changes on the same edge that updates `ridx`.
- Synchronizer latency is 2 cycles, so SCAN_DIV ≥ 3 guarantees the sampled value reflects the currently driven row.
- Press latency: from `cols_n` going low during the sampled row to lock is at most 4·SCAN_DIV + 2 cycles.
- `new_key` is high exactly one cycle: the first cycle in PRESSED.
- `key_pressed` rises in the same cycle as `new_key`.
- `key_pressed` falls RELEASE_CYCLES cycles after the first released sample, counted in synchronized cycles.
- A release glitch shorter than RELEASE_CYCLES resets `rel` and causes no new `new_key`.
- Widths:
  - `cnt` is $clog2(SCAN_DIV) bits.
  - `rel` is $clog2(RELEASE_CYCLES+1) bits.
  - `ridx` is 2 bits and wraps 3→0.

## Structure
- Package `keypad_pkg`:
  - `state_t` enum {SCAN, PRESSED}.
  - Function `key_map(row_idx, col_idx)` returning logic [3:0].
  - Constants `NROWS`=4, `NCOLS`=4.
  - The debouncer and display stages import the same package.
- Sub-module `sync_2ff`, parameterized width WIDTH, with ports `clk`, `reset`, `d`, `q`; instantiated with WIDTH=4 for the columns.
- Top file holds the FSM, the counters, the priority encoder for the lowest column, and the output registers.

## Test plan
All scenarios use SCAN_DIV=4 and RELEASE_CYCLES=3.
1. Reset pulse, no keys → `rows_n` cycles 1110, 1101, 1011, 0111, 1110, each held 4 cycles; `key_pressed`=0 and `new_key`=0 throughout.
2. Hold key "5" (row1 low pulls col1 low) → single `new_key` pulse; `key_code`=4'h5, `row_pressed`=0010, `col_pressed`=0010; `rows_n` frozen at 1101 while held.
3. Release "5" for 3 cycles → `key_pressed` falls; scanning resumes at row2 (`rows_n`=1011); `key_code` stays 5.
4. While "5" is locked, press "9" too, then release "5" only → no second `new_key` while "5" is held. After "5" releases and scan resumes, "9" locks: `key_code`=9, one `new_key`.
5. Press "4" and "6" together (row1, cols 0 and 2) → lock on col0: `key_code`=4, `col_pressed`=0001.
6. During PRESSED: a 1-cycle release glitch does not unlock and gives no extra `new_key`. Then assert `reset` mid-press → next cycle all outputs are at their reset values, `rows_n`=1110.
